// File: rtl/axi_sysbus_slave.sv
// AXI single-beat slave bridging AW/W/AR/B/R channels onto a strobe/ack system bus.
// Captures each address/data channel in its own holding register, arbitrates
// between a pending write and a pending read, and guards every bus access
// with an ack timeout that turns into a SLVERR response.
module axi_sysbus_slave #(
   parameter int AW = 32,
   parameter int DW = 64,
   parameter int IW = 4,
   parameter int TO = 32
) (
   input  logic            aclk_i,
   input  logic            rst_i,
   input  logic [IW-1:0]   awid_i,
   input  logic [AW-1:0]   awaddr_i,
   input  logic            awvalid_i,
   output logic            awready_o,
   input  logic [DW-1:0]   wdata_i,
   input  logic [DW/8-1:0] wstrb_i,
   input  logic            wlast_i,
   input  logic            wvalid_i,
   output logic            wready_o,
   output logic [IW-1:0]   bid_o,
   output logic [1:0]      bresp_o,
   output logic            bvalid_o,
   input  logic            bready_i,
   input  logic [IW-1:0]   arid_i,
   input  logic [AW-1:0]   araddr_i,
   input  logic            arvalid_i,
   output logic            arready_o,
   output logic [IW-1:0]   rid_o,
   output logic [DW-1:0]   rdata_o,
   output logic [1:0]      rresp_o,
   output logic            rlast_o,
   output logic            rvalid_o,
   input  logic            rready_i,
   output logic [AW-1:0]   sys_addr_o,
   output logic [DW-1:0]   sys_wdata_o,
   output logic [DW/8-1:0] sys_sel_o,
   output logic            sys_wen_o,
   output logic            sys_ren_o,
   input  logic [DW-1:0]   sys_rdata_i,
   input  logic            sys_err_i,
   input  logic            sys_ack_i
);

   localparam int CW = $clog2(TO + 1);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {IDLE, WR_STB, RD_STB, WAIT_ACK, B_RESP, R_RESP} state_t;

   state_t            state_q, state_d;
   logic              aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
   logic [IW-1:0]     awid_q, awid_d, arid_q, arid_d;
   logic [AW-1:0]     awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [DW/8-1:0]   wstrb_q, wstrb_d;
   logic              awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
   logic              wr_next_q, wr_next_d, is_wr_q, is_wr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [AW-1:0]     sys_addr_q, sys_addr_d;
   logic [DW-1:0]     sys_wdata_q, sys_wdata_d;
   logic [DW/8-1:0]   sys_sel_q, sys_sel_d;
   logic [IW-1:0]     bid_q, bid_d, rid_q, rid_d;
   logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d, resp;
   logic [DW-1:0]     rdata_q, rdata_d;

   logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
   logic wr_rdy, rd_rdy, contested, pick_wr, pick_rd;
   logic unused_wlast;

   // Single-beat only: the last flag carries no information here.
   assign unused_wlast = wlast_i;

   assign aw_hs = awvalid_i & awready_q;
   assign w_hs  = wvalid_i  & wready_q;
   assign ar_hs = arvalid_i & arready_q;
   assign b_hs  = (state_q == B_RESP) & bready_i;
   assign r_hs  = (state_q == R_RESP) & rready_i;

   assign wr_rdy    = aw_full_q & w_full_q;
   assign rd_rdy    = ar_full_q;
   assign contested = wr_rdy & rd_rdy;
   assign pick_wr   = wr_rdy & (~rd_rdy | wr_next_q);
   assign pick_rd   = rd_rdy & ~pick_wr;

   // Holding registers: fill on the channel handshake, empty on the matching response handshake.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      aw_full_d = aw_full_q;
      awid_d    = awid_q;
      awaddr_d  = awaddr_q;
      w_full_d  = w_full_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      ar_full_d = ar_full_q;
      arid_d    = arid_q;
      araddr_d  = araddr_q;
      if (aw_hs) begin
         aw_full_d = 1'b1;
         awid_d    = awid_i;
         awaddr_d  = awaddr_i;
      end else if (b_hs) begin
         aw_full_d = 1'b0;
      end
      if (w_hs) begin
         w_full_d = 1'b1;
         wdata_d  = wdata_i;
         wstrb_d  = wstrb_i;
      end else if (b_hs) begin
         w_full_d = 1'b0;
      end
      if (ar_hs) begin
         ar_full_d = 1'b1;
         arid_d    = arid_i;
         araddr_d  = araddr_i;
      end else if (r_hs) begin
         ar_full_d = 1'b0;
      end
      // Ready is registered so it reads 0 while reset is held.
      awready_d = ~aw_full_d;
      wready_d  = ~w_full_d;
      arready_d = ~ar_full_d;
   end

   // Access FSM: arbitration, strobe, ack/timeout wait and response hand-back.
   always_comb begin
      state_d     = state_q;
      wr_next_d   = wr_next_q;
      is_wr_d     = is_wr_q;
      cnt_d       = cnt_q;
      sys_addr_d  = sys_addr_q;
      sys_wdata_d = sys_wdata_q;
      sys_sel_d   = sys_sel_q;
      bid_d       = bid_q;
      bresp_d     = bresp_q;
      rid_d       = rid_q;
      rresp_d     = rresp_q;
      rdata_d     = rdata_q;
      resp        = (sys_ack_i && !sys_err_i) ? RESP_OKAY : RESP_SLVERR;
      unique case (state_q)
         IDLE: begin
            if (pick_wr) begin
               is_wr_d = 1'b1;
               if (contested) wr_next_d = ~wr_next_q;
               if (wstrb_q == '0) begin
                  // Nothing to write: answer immediately without touching the bus.
                  state_d = B_RESP;
                  bid_d   = awid_q;
                  bresp_d = RESP_OKAY;
               end else begin
                  state_d     = WR_STB;
                  sys_addr_d  = awaddr_q;
                  sys_wdata_d = wdata_q;
                  sys_sel_d   = wstrb_q;
               end
            end else if (pick_rd) begin
               is_wr_d    = 1'b0;
               if (contested) wr_next_d = ~wr_next_q;
               state_d    = RD_STB;
               sys_addr_d = araddr_q;
               sys_sel_d  = '1;
            end
         end
         WR_STB, RD_STB: begin
            state_d = WAIT_ACK;
            cnt_d   = '0;
         end
         WAIT_ACK: begin
            cnt_d = cnt_q + CW'(1);
            if (sys_ack_i || cnt_q == CW'(TO - 1)) begin
               cnt_d = '0;
               if (is_wr_q) begin
                  state_d = B_RESP;
                  bid_d   = awid_q;
                  bresp_d = resp;
               end else begin
                  state_d = R_RESP;
                  rid_d   = arid_q;
                  rresp_d = resp;
                  rdata_d = sys_ack_i ? sys_rdata_i : '0;
               end
            end
         end
         B_RESP: if (bready_i) state_d = IDLE;
         R_RESP: if (rready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge aclk_i) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      if (rst_i) begin
         state_q     <= IDLE;
         aw_full_q   <= 1'b0;
         w_full_q    <= 1'b0;
         ar_full_q   <= 1'b0;
         awid_q      <= '0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         arid_q      <= '0;
         araddr_q    <= '0;
         awready_q   <= 1'b0;
         wready_q    <= 1'b0;
         arready_q   <= 1'b0;
         wr_next_q   <= 1'b1;
         is_wr_q     <= 1'b0;
         cnt_q       <= '0;
         sys_addr_q  <= '0;
         sys_wdata_q <= '0;
         sys_sel_q   <= '0;
         bid_q       <= '0;
         bresp_q     <= '0;
         rid_q       <= '0;
         rresp_q     <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         aw_full_q   <= aw_full_d;
         w_full_q    <= w_full_d;
         ar_full_q   <= ar_full_d;
         awid_q      <= awid_d;
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         arid_q      <= arid_d;
         araddr_q    <= araddr_d;
         awready_q   <= awready_d;
         wready_q    <= wready_d;
         arready_q   <= arready_d;
         wr_next_q   <= wr_next_d;
         is_wr_q     <= is_wr_d;
         cnt_q       <= cnt_d;
         sys_addr_q  <= sys_addr_d;
         sys_wdata_q <= sys_wdata_d;
         sys_sel_q   <= sys_sel_d;
         bid_q       <= bid_d;
         bresp_q     <= bresp_d;
         rid_q       <= rid_d;
         rresp_q     <= rresp_d;
         rdata_q     <= rdata_d;
      end
   end

   assign awready_o   = awready_q;
   assign wready_o    = wready_q;
   assign arready_o   = arready_q;
   assign bid_o       = bid_q;
   assign bresp_o     = bresp_q;
   assign bvalid_o    = (state_q == B_RESP);
   assign rid_o       = rid_q;
   assign rdata_o     = rdata_q;
   assign rresp_o     = rresp_q;
   assign rvalid_o    = (state_q == R_RESP);
   assign rlast_o     = (state_q == R_RESP);
   assign sys_addr_o  = sys_addr_q;
   assign sys_wdata_o = sys_wdata_q;
   assign sys_sel_o   = sys_sel_q;
   assign sys_wen_o   = (state_q == WR_STB);
   assign sys_ren_o   = (state_q == RD_STB);

endmodule
